// File: rtl/uart_rx_filter.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_filter
// Purpose  : Receive-line conditioner for the 16550-style UART. Samples each
//            rx line on a shared prescaler tick, keeps a WINDOW-deep sample
//            history per channel and produces a cleaned level (majority vote
//            or unanimous-window hysteresis) plus edge and noise pulses.
// Ports    : clk_i        - clock
//            nrst_i       - asynchronous active-low reset
//            div_i        - prescaler terminal value (sample every div_i+1 clks)
//            mode_i       - 0 = majority vote, 1 = hysteresis
//            rxd_i        - rx lines, already synchronised to clk_i
//            rxd_clean_o  - filtered line levels (registered)
//            rise_o       - 1-cycle pulse when rxd_clean_o goes 0->1
//            fall_o       - 1-cycle pulse when rxd_clean_o goes 1->0
//            noise_o      - 1-cycle pulse on a tick whose window is mixed
//            tick_o       - 1-cycle pulse following every sample tick
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_filter #(
  parameter int CHANNELS = 1,
  parameter int WINDOW   = 5,
  parameter int DIV_W    = 4
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic [DIV_W-1:0]    div_i,
  input  logic                mode_i,
  input  logic [CHANNELS-1:0] rxd_i,
  output logic [CHANNELS-1:0] rxd_clean_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] noise_o,
  output logic                tick_o
);

  localparam int                  c_ones_w = $clog2(WINDOW + 1);
  localparam logic [c_ones_w-1:0] c_half   = c_ones_w'(WINDOW / 2);
  localparam logic [c_ones_w-1:0] c_full   = c_ones_w'(WINDOW);

  // --------------------------------------------------------------------------
  // Shared prescaler. Using >= rather than == means lowering div_i below the
  // running count yields a tick on the very next clock instead of a wrap,
  // and the count can never run past div_i (hence never past the DIV_W max).
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;
  logic             w_tick;

  assign w_tick = (r_cnt >= div_i);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign tick_o = r_tick;

  // --------------------------------------------------------------------------
  // Per-channel filter. Only the WINDOW-1 most recent samples are stored; the
  // current window is those plus the live rxd_i bit, so the decision and the
  // history update happen on the same tick edge with no extra latency.
  // --------------------------------------------------------------------------
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    logic [WINDOW-2:0]   r_hist;
    logic [WINDOW-1:0]   w_win;
    logic [c_ones_w-1:0] w_ones;
    logic                w_clean_nxt;
    logic                r_clean;
    logic                r_rise;
    logic                r_fall;
    logic                r_noise;

    assign w_win = {r_hist, rxd_i[ch]};

    always_comb begin
      w_ones = '0;
      for (int i = 0; i < WINDOW; i++) begin
        w_ones = w_ones + c_ones_w'(w_win[i]);
      end
    end

    // Hysteresis only moves on a unanimous window; anything mixed holds.
    always_comb begin
      w_clean_nxt = r_clean;
      if (!mode_i) begin
        w_clean_nxt = (w_ones > c_half);
      end else if (w_ones == c_full) begin
        w_clean_nxt = 1'b1;
      end else if (w_ones == '0) begin
        w_clean_nxt = 1'b0;
      end
    end

    // Idle line is high, so history and level reset to all ones.
    always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
        r_hist  <= '1;
        r_clean <= 1'b1;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_noise <= 1'b0;
      end else if (w_tick) begin
        r_hist  <= w_win[WINDOW-2:0];
        r_clean <= w_clean_nxt;
        r_rise  <= w_clean_nxt & ~r_clean;
        r_fall  <= ~w_clean_nxt & r_clean;
        r_noise <= (w_ones != '0) && (w_ones != c_full);
      end else begin
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_noise <= 1'b0;
      end
    end

    assign rxd_clean_o[ch] = r_clean;
    assign rise_o[ch]      = r_rise;
    assign fall_o[ch]      = r_fall;
    assign noise_o[ch]     = r_noise;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_filter
// Purpose  : Self-checking bench for uart_rx_filter (4 channels, WINDOW 5).
//            A reference model keeps each channel's recent samples in a queue
//            and pushes the expected outputs of every tick into a scoreboard;
//            a monitor pops and compares whenever the DUT shows tick_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_filter;

  localparam int CH = 4;
  localparam int W  = 5;
  localparam int DW = 4;

  logic          clk  = 1'b0;
  logic          nrst = 1'b0;
  logic [DW-1:0] div  = '0;
  logic          mode = 1'b0;
  logic [CH-1:0] rxd  = '0;
  logic [CH-1:0] clean, rise, fall, noise;
  logic          tick;

  always #5 clk = ~clk;

  uart_rx_filter #(
    .CHANNELS (CH),
    .WINDOW   (W),
    .DIV_W    (DW)
  ) dut (
    .clk_i       (clk),
    .nrst_i      (nrst),
    .div_i       (div),
    .mode_i      (mode),
    .rxd_i       (rxd),
    .rxd_clean_o (clean),
    .rise_o      (rise),
    .fall_o      (fall),
    .noise_o     (noise),
    .tick_o      (tick)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  localparam logic [4*CH:0] RESET_VEC = {{CH{1'b1}}, {(3*CH+1){1'b0}}};

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct {
    longint        cyc;
    logic [CH-1:0] clean;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] noise;
  } exp_t;

  exp_t          q[$];
  exp_t          m_e;
  exp_t          mon_e;
  longint        cyc = 0;
  int            m_since = 0;     // clocks since last sample
  bit            m_tick_now = 1'b0;
  logic [CH-1:0] m_clean = '1;
  bit            smp[CH][$];

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q.delete();
      m_since    = 0;
      m_tick_now = 1'b0;
      m_clean    = '1;
      for (int c = 0; c < CH; c++) begin
        smp[c].delete();
        for (int i = 0; i < W; i++) smp[c].push_back(1'b1);
      end
    end else begin
      cyc++;
      m_tick_now = (m_since >= int'(div));
      if (m_tick_now) begin
        m_since = 0;
        m_e.cyc = cyc;
        for (int c = 0; c < CH; c++) begin
          int  ones;
          bit  old_lvl, new_lvl;
          smp[c].push_back(rxd[c]);
          void'(smp[c].pop_front());
          ones = 0;
          for (int i = 0; i < smp[c].size(); i++) ones += int'(smp[c][i]);
          old_lvl = m_clean[c];
          if (!mode)            new_lvl = (2 * ones > W);
          else if (ones == W)   new_lvl = 1'b1;
          else if (ones == 0)   new_lvl = 1'b0;
          else                  new_lvl = old_lvl;
          m_e.noise[c] = (ones > 0) && (ones < W);
          m_e.rise[c]  = !old_lvl && new_lvl;
          m_e.fall[c]  = old_lvl && !new_lvl;
          m_clean[c]   = new_lvl;
        end
        m_e.clean = m_clean;
        q.push_back(m_e);
      end else begin
        m_since++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!nrst) begin
      chk("reset_outputs", 32'({clean, rise, fall, noise, tick}), 32'(RESET_VEC));
    end else if (tick) begin
      if (q.size() == 0) begin
        chk("unexpected_tick", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("tick_cycle", cyc[31:0], mon_e.cyc[31:0]);
        chk("clean", 32'(clean), 32'(mon_e.clean));
        chk("rise",  32'(rise),  32'(mon_e.rise));
        chk("fall",  32'(fall),  32'(mon_e.fall));
        chk("noise", 32'(noise), 32'(mon_e.noise));
      end
    end else begin
      if (q.size() != 0 && q[0].cyc <= cyc) begin
        chk("missing_tick", 32'd0, 32'd1);
        void'(q.pop_front());
      end
      chk("idle_pulses", 32'({rise, fall, noise}), 32'd0);
      chk("idle_clean", 32'(clean), 32'(m_clean));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  // Present one value on rxd and hold it for exactly one sample tick.
  task automatic put(input logic [CH-1:0] v);
    @(negedge clk);
    rxd = v;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (m_tick_now) break;
    end
  endtask

  // Assert reset mid-cycle, check outputs drop at once, release with div d
  // just after a clock edge so the next edge is edge 1.
  task automatic do_reset(input logic [DW-1:0] d);
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_reset_immediate", 32'({clean, rise, fall, noise, tick}), 32'(RESET_VEC));
    mode = 1'($urandom);
    div  = DW'($urandom);
    rxd  = '0;
    repeat (3) @(posedge clk);
    div = d;
    #3;
    nrst = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    // Reset with line low, release with div 3: tick_o after edges 4 and 8.
    do_reset(4'd3);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      chk("tick_after_reset", 32'(tick), 32'((e % 4) == 0));
    end

    // Majority step down (from reset history), step up, step down.
    mode = 1'b0;
    repeat (6) put('0);
    repeat (6) put('1);
    repeat (6) put('0);
    repeat (6) put('1);

    // Glitch rejection: 2-sample low rejected, 3-sample low passes.
    repeat (2) put('0);
    repeat (6) put('1);
    repeat (3) put('0);
    repeat (6) put('1);

    // Hysteresis: 0,0,0,0,1 repeated holds high; five zeros fall.
    mode = 1'b1;
    repeat (4) begin
      repeat (4) put('0);
      put('1);
    end
    repeat (5) put('0);
    repeat (2) put('1);
    repeat (5) put('1);

    // Distinct per-channel patterns, mode switching midway.
    for (int s = 0; s < 40; s++) begin
      if (s == 20) mode = ~mode;
      put({1'(s % 5 == 0), 1'($urandom), 1'((s / 3) % 2), 1'((s % 7) < 3)});
    end

    // Prescaler: div 15 -> 2 with count at 9, then tick every 3 clocks.
    do_reset(4'd15);
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1;
      chk("div15_no_tick", 32'(tick), 32'd0);
    end
    div = 4'd2;
    for (int e = 10; e <= 16; e++) begin
      @(posedge clk);
      #1;
      chk("div_lowered_tick", 32'(tick), 32'((e == 10) || (e == 13) || (e == 16)));
    end

    // div 0: a tick every clock, majority step done in three clocks.
    div  = 4'd0;
    mode = 1'b0;
    repeat (6) put('1);
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      chk("div0_tick_every_cycle", 32'(tick), 32'd1);
    end
    put('0);
    put('0);
    chk("div0_step_two_clocks", 32'(clean), 32'({CH{1'b1}}));
    put('0);
    chk("div0_step_three_clocks", 32'(clean), 32'd0);

    // Randomised traffic with a mid-run reset.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset(DW'($urandom_range(0, 2)));
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) rxd[c] = ~rxd[c];
      end
      if ($urandom_range(0, 99) == 0) div = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) mode = ~mode;
    end

    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
